tlb_bank: RTL and testbench
===========================

TLB_BANK -- requirements
Module: tlb_bank

Interface
REQ-001 Parameter TLBNUM, 16, number of entries; a power of two from 4 to 64.
REQ-002 Parameter TLBIDLEN, $clog2(TLBNUM), width of an entry index.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 s0/s1/s2_vppn  in  19 each  search VA[31:13] for the fetch, lsu-a and lsu-b ports.
REQ-006 s0/s1/s2_va_bit12  in  1 each  search VA[12].
REQ-007 s0/s1/s2_asid  in  10 each  search ASID.
REQ-008 s0/s1/s2_result  out  tlb_result_t each  fields: found, index, ppn, ps, plv, mat, d, v.
REQ-009 invtlb_valid  in  1  INVTLB request.
REQ-010 invtlb_op  in  5  INVTLB operation code.
REQ-011 invtlb_asid  in  10  INVTLB ASID.
REQ-012 invtlb_va  in  32  INVTLB virtual address.
REQ-013 invtlb_busy  out  1  sweep in progress; the pipeline holds while this is high.
REQ-014 we  in  1  write strobe.
REQ-015 w_index  in  TLBIDLEN  entry to write.
REQ-016 w_entry  in  tlb_entry_t  data to write.
REQ-017 r_index  in  TLBIDLEN  entry to read.
REQ-018 r_entry  out  tlb_entry_t  contents of entry r_index.

Function
REQ-019 Searches and reads are combinational from current entry state; each has zero-cycle latency.
REQ-020 Entry i hits when all three hold: e=1; g=1 or asid equals s_asid; VPPN matches.
REQ-021 VPPN match for ps=12: all 19 bits of vppn. For ps=21: vppn[18:9] only.
REQ-022 Odd-page select: va_bit12 when ps=12; vppn[8] when ps=21; select=1 returns the ppn1/plv1/mat1/d1/v1 fields.
REQ-023 Multiple hits: the lowest index wins.
REQ-024 Miss: found=0 and every other result field is 0.
REQ-025 A write updates entry w_index at the clock edge and is visible to searches and reads from the next cycle.
REQ-026 FSM IDLE -> SWEEP on invtlb_valid with a legal op (0-6) while busy=0; the op, asid and va are latched at that edge.
REQ-027 In SWEEP a counter runs 0..TLBNUM-1; entry[cnt] is evaluated and, if it matches, has e cleared at that cycle's edge.
REQ-028 The FSM returns to IDLE after cnt=TLBNUM-1.
REQ-029 invtlb_busy=1 exactly during SWEEP, i.e. for TLBNUM cycles.
REQ-030 Op 0 or 1: clear every entry.
REQ-031 Op 2: clear entries with g=1. Op 3: clear entries with g=0.
REQ-032 Op 4: clear entries with g=0 and asid match.
REQ-033 Op 5: clear entries with g=0, asid match and va match.
REQ-034 Op 6: clear entries where (g=1 or asid match) and va match.
REQ-035 INVTLB va match uses invtlb_va[31:13] with the same ps rule as REQ-021.
REQ-036 Op >6: no action and busy stays 0; the illegal-instruction exception is raised by the pipeline.
REQ-037 invtlb_valid while busy=1 is ignored.
REQ-038 we while busy=1 is ignored.
REQ-039 we and an accepted invtlb_valid in the same cycle: the write commits first, and the sweep then evaluates the written entry.
REQ-040 Searches during SWEEP see the partially invalidated state; no bypass is provided.

Reset
REQ-041 With reset low: every entry field is 0 (so e=0), FSM is IDLE, cnt=0, invtlb_busy=0.
REQ-042 Consequently every search reports found=0 while reset is low and after release.
REQ-043 Reset asserted mid-sweep aborts the sweep immediately.

Structure
REQ-044 TLBNUM, TLBIDLEN, tlb_entry_t and tlb_result_t live in the shared definitions package.
REQ-045 Opcode constants INVTLB_ALL0, INVTLB_ALL1, INVTLB_G1, INVTLB_G0, INVTLB_ASID, INVTLB_ASID_VA and INVTLB_GASID_VA also live there.
REQ-046 One sub-module, tlb_match: combinational per-entry hit plus odd-page select, instantiated for each search port and reused by the sweep evaluator.

Verification
REQ-047 Reset release -> all three ports found=0; r_entry of index 5 is all zero.
REQ-048 Write idx 3 {e=1, g=0, asid=0x12, ps=12, vppn=0x1234, ppn1=0xABCDE, v1=1}, then search vppn 0x1234, bit12=1, asid 0x12 -> found=1, index=3, ppn=0xABCDE, v=1.
REQ-049 Same search with asid 0x13 -> found=0.
REQ-050 ps=21 entry at idx 7, vppn=0x1FE00 -> search vppn 0x1FFFF hits index 7 with the odd page.
REQ-051 Entries {0: g=1}, {1: g=0, asid=4}, {2: g=0, asid=5}; op 4, asid 4 -> busy high exactly 16 cycles; afterwards only entry 1 has e=0.
REQ-052 we to idx 9 in the same cycle as op 0 accepted -> entry 9 ends with e=0; a second invtlb_valid at sweep cycle 8 is ignored and busy drops at cycle 16.
REQ-053 Op 7 -> busy stays 0 and no entry changes.
REQ-054 Reset pulled low at sweep cycle 5 -> busy=0 immediately and all entries are invalid.

Source files
------------

// File: rtl/tlb_bank_pkg.sv
// Shared TLB definitions: geometry, entry/result layouts, INVTLB opcodes
// and the sweep FSM state type.
package tlb_bank_pkg;

    localparam int TLBNUM   = 16;
    localparam int TLBIDLEN = $clog2(TLBNUM);

    localparam logic [4:0] INVTLB_ALL0     = 5'd0;
    localparam logic [4:0] INVTLB_ALL1     = 5'd1;
    localparam logic [4:0] INVTLB_G1       = 5'd2;
    localparam logic [4:0] INVTLB_G0       = 5'd3;
    localparam logic [4:0] INVTLB_ASID     = 5'd4;
    localparam logic [4:0] INVTLB_ASID_VA  = 5'd5;
    localparam logic [4:0] INVTLB_GASID_VA = 5'd6;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    typedef struct packed {
        logic        e;
        logic        g;
        logic [9:0]  asid;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic                found;
        logic [TLBIDLEN-1:0] index;
        logic [19:0]         ppn;
        logic [5:0]          ps;
        logic [1:0]          plv;
        logic [1:0]          mat;
        logic                d;
        logic                v;
    } tlb_result_t;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } inv_state_t;

endpackage

// File: rtl/tlb_match.sv
// Per-entry comparator: VA/ASID match, full hit and odd/even page select.
// Purely combinational; used by the search ports and the INVTLB sweep.
module tlb_match
    import tlb_bank_pkg::*;
(
    input  tlb_entry_t  i_entry,
    input  logic [18:0] i_vppn,
    input  logic        i_va_bit12,
    input  logic [9:0]  i_asid,
    output logic        o_va_match,
    output logic        o_asid_match,
    output logic        o_hit,
    output tlb_page_t   o_page
);

    logic w_huge;
    logic w_odd;

    assign w_huge       = (i_entry.ps == PS_2M);
    // A 2MB entry pair spans VA[31:22], so only vppn[18:9] is compared.
    assign o_va_match   = w_huge ? (i_entry.vppn[18:9] == i_vppn[18:9])
                                 : (i_entry.vppn == i_vppn);
    assign o_asid_match = (i_entry.asid == i_asid);
    assign o_hit        = i_entry.e & (i_entry.g | o_asid_match) & o_va_match;
    assign w_odd        = w_huge ? i_vppn[8] : i_va_bit12;

    always_comb begin
        if (w_odd) begin
            o_page.ppn = i_entry.ppn1;
            o_page.plv = i_entry.plv1;
            o_page.mat = i_entry.mat1;
            o_page.d   = i_entry.d1;
            o_page.v   = i_entry.v1;
        end else begin
            o_page.ppn = i_entry.ppn0;
            o_page.plv = i_entry.plv0;
            o_page.mat = i_entry.mat0;
            o_page.d   = i_entry.d0;
            o_page.v   = i_entry.v0;
        end
    end

endmodule

// File: rtl/tlb_bank.sv
// TLB entry bank: three zero-latency search ports, a read port, one write
// port and an INVTLB sweep that walks one entry per cycle while busy.
module tlb_bank
    import tlb_bank_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [18:0]         s0_vppn,
    input  logic                s0_va_bit12,
    input  logic [9:0]          s0_asid,
    output tlb_result_t         s0_result,
    input  logic [18:0]         s1_vppn,
    input  logic                s1_va_bit12,
    input  logic [9:0]          s1_asid,
    output tlb_result_t         s1_result,
    input  logic [18:0]         s2_vppn,
    input  logic                s2_va_bit12,
    input  logic [9:0]          s2_asid,
    output tlb_result_t         s2_result,
    input  logic                invtlb_valid,
    input  logic [4:0]          invtlb_op,
    input  logic [9:0]          invtlb_asid,
    input  logic [31:0]         invtlb_va,
    output logic                invtlb_busy,
    input  logic                we,
    input  logic [TLBIDLEN-1:0] w_index,
    input  tlb_entry_t          w_entry,
    input  logic [TLBIDLEN-1:0] r_index,
    output tlb_entry_t          r_entry
);

    tlb_entry_t          r_tlb [TLBNUM];
    inv_state_t          r_state;
    logic [TLBIDLEN-1:0] r_cnt;
    logic                r_busy;
    logic [4:0]          r_op;
    logic [9:0]          r_inv_asid;
    logic [18:0]         r_inv_vppn;

    logic [18:0]               w_q_vppn [3];
    logic                      w_q_b12  [3];
    logic [9:0]                w_q_asid [3];
    logic [2:0][TLBNUM-1:0]    w_s_hit;
    logic [2:0][TLBNUM-1:0]    w_s_vmatch;
    logic [2:0][TLBNUM-1:0]    w_s_amatch;
    tlb_page_t                 w_s_page [3][TLBNUM];
    tlb_result_t               w_res    [3];

    tlb_entry_t w_swp_ent;
    logic       w_swp_vmatch;
    logic       w_swp_amatch;
    logic       w_swp_hit;
    tlb_page_t  w_swp_page;
    logic       w_swp_clr;
    logic       w_inv_go;
    logic       w_unused;

    assign w_q_vppn[0] = s0_vppn;
    assign w_q_vppn[1] = s1_vppn;
    assign w_q_vppn[2] = s2_vppn;
    assign w_q_b12[0]  = s0_va_bit12;
    assign w_q_b12[1]  = s1_va_bit12;
    assign w_q_b12[2]  = s2_va_bit12;
    assign w_q_asid[0] = s0_asid;
    assign w_q_asid[1] = s1_asid;
    assign w_q_asid[2] = s2_asid;

    for (genvar p = 0; p < 3; p++) begin : g_port
        for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
            tlb_match u_match (
                .i_entry      (r_tlb[i]),
                .i_vppn       (w_q_vppn[p]),
                .i_va_bit12   (w_q_b12[p]),
                .i_asid       (w_q_asid[p]),
                .o_va_match   (w_s_vmatch[p][i]),
                .o_asid_match (w_s_amatch[p][i]),
                .o_hit        (w_s_hit[p][i]),
                .o_page       (w_s_page[p][i])
            );
        end
    end

    // Scan downwards so the lowest hitting index is the last one written.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_res[p] = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (w_s_hit[p][i]) begin
                    w_res[p].found = 1'b1;
                    w_res[p].index = TLBIDLEN'(i);
                    w_res[p].ppn   = w_s_page[p][i].ppn;
                    w_res[p].ps    = r_tlb[i].ps;
                    w_res[p].plv   = w_s_page[p][i].plv;
                    w_res[p].mat   = w_s_page[p][i].mat;
                    w_res[p].d     = w_s_page[p][i].d;
                    w_res[p].v     = w_s_page[p][i].v;
                end
            end
        end
    end

    assign s0_result   = w_res[0];
    assign s1_result   = w_res[1];
    assign s2_result   = w_res[2];
    assign r_entry     = r_tlb[r_index];
    assign invtlb_busy = r_busy;

    assign w_swp_ent = r_tlb[r_cnt];

    tlb_match u_swp_match (
        .i_entry      (w_swp_ent),
        .i_vppn       (r_inv_vppn),
        .i_va_bit12   (1'b0),
        .i_asid       (r_inv_asid),
        .o_va_match   (w_swp_vmatch),
        .o_asid_match (w_swp_amatch),
        .o_hit        (w_swp_hit),
        .o_page       (w_swp_page)
    );

    always_comb begin
        w_swp_clr = 1'b0;
        case (r_op)
            INVTLB_ALL0, INVTLB_ALL1: w_swp_clr = 1'b1;
            INVTLB_G1:                w_swp_clr = w_swp_ent.g;
            INVTLB_G0:                w_swp_clr = ~w_swp_ent.g;
            INVTLB_ASID:              w_swp_clr = ~w_swp_ent.g & w_swp_amatch;
            INVTLB_ASID_VA:           w_swp_clr = ~w_swp_ent.g & w_swp_amatch & w_swp_vmatch;
            INVTLB_GASID_VA:          w_swp_clr = w_swp_hit;
            default:                  w_swp_clr = 1'b0;
        endcase
    end

    assign w_inv_go = invtlb_valid & ~r_busy & (invtlb_op <= INVTLB_GASID_VA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_op       <= '0;
            r_inv_asid <= '0;
            r_inv_vppn <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_inv_go) begin
                        r_state    <= ST_SWEEP;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_op       <= invtlb_op;
                        r_inv_asid <= invtlb_asid;
                        r_inv_vppn <= invtlb_va[31:13];
                    end
                end
                ST_SWEEP: begin
                    if (r_cnt == TLBIDLEN'(TLBNUM - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Writes are only accepted while idle, so they never collide with a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_tlb[i] <= '0;
            end
        end else begin
            if (we && !r_busy) begin
                r_tlb[w_index] <= w_entry;
            end
            if ((r_state == ST_SWEEP) && w_swp_clr) begin
                r_tlb[r_cnt].e <= 1'b0;
            end
        end
    end

    assign w_unused = ^{w_swp_page, w_s_vmatch, w_s_amatch, invtlb_va[12:0]};

endmodule

// File: tb/tb_tlb_bank.sv
// Randomized bench for tlb_bank against an address-arithmetic reference model.
module tb_tlb_bank;
    import tlb_bank_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [18:0]         s0_vppn = '0, s1_vppn = '0, s2_vppn = '0;
    logic                s0_va_bit12 = 1'b0, s1_va_bit12 = 1'b0, s2_va_bit12 = 1'b0;
    logic [9:0]          s0_asid = '0, s1_asid = '0, s2_asid = '0;
    tlb_result_t         s0_result, s1_result, s2_result;
    logic                invtlb_valid = 1'b0;
    logic [4:0]          invtlb_op = '0;
    logic [9:0]          invtlb_asid = '0;
    logic [31:0]         invtlb_va = '0;
    logic                invtlb_busy;
    logic                we = 1'b0;
    logic [TLBIDLEN-1:0] w_index = '0;
    tlb_entry_t          w_entry = '0;
    logic [TLBIDLEN-1:0] r_index = '0;
    tlb_entry_t          r_entry;

    tlb_entry_t m_tlb [TLBNUM];
    int n_checks = 0;
    int n_errors = 0;

    tlb_bank dut (
        .clk(clk), .reset(reset),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid), .s0_result(s0_result),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid), .s1_result(s1_result),
        .s2_vppn(s2_vppn), .s2_va_bit12(s2_va_bit12), .s2_asid(s2_asid), .s2_result(s2_result),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
        .invtlb_va(invtlb_va), .invtlb_busy(invtlb_busy),
        .we(we), .w_index(w_index), .w_entry(w_entry),
        .r_index(r_index), .r_entry(r_entry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: compare the VA against the entry's page-pair span.
    function automatic tlb_result_t ref_search(input logic [18:0] vppn, input logic b12,
                                               input logic [9:0] asid);
        tlb_result_t r;
        logic [31:0] va;
        logic [31:0] eva;
        int          sh;
        logic        odd;
        r  = '0;
        va = {vppn, b12, 12'h000};
        for (int i = 0; i < TLBNUM; i++) begin
            sh  = (m_tlb[i].ps == 6'd21) ? 22 : 13;
            eva = {m_tlb[i].vppn, 13'h0000};
            if (m_tlb[i].e && (m_tlb[i].g || m_tlb[i].asid == asid) && ((va >> sh) == (eva >> sh))) begin
                odd     = va[sh-1];
                r.found = 1'b1;
                r.index = TLBIDLEN'(i);
                r.ps    = m_tlb[i].ps;
                r.ppn   = odd ? m_tlb[i].ppn1 : m_tlb[i].ppn0;
                r.plv   = odd ? m_tlb[i].plv1 : m_tlb[i].plv0;
                r.mat   = odd ? m_tlb[i].mat1 : m_tlb[i].mat0;
                r.d     = odd ? m_tlb[i].d1 : m_tlb[i].d0;
                r.v     = odd ? m_tlb[i].v1 : m_tlb[i].v0;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic inv_kills(input tlb_entry_t e, input logic [4:0] op,
                                       input logic [9:0] asid, input logic [31:0] va);
        int   sh;
        logic vm;
        logic am;
        sh = (e.ps == 6'd21) ? 22 : 13;
        vm = ((va >> sh) == ({e.vppn, 13'h0000} >> sh));
        am = (e.asid == asid);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return e.g;
            5'd3:       return !e.g;
            5'd4:       return !e.g && am;
            5'd5:       return !e.g && am && vm;
            5'd6:       return (e.g || am) && vm;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic void ref_apply_inv(input logic [4:0] op, input logic [9:0] asid,
                                          input logic [31:0] va);
        for (int i = 0; i < TLBNUM; i++)
            if (inv_kills(m_tlb[i], op, asid, va)) m_tlb[i].e = 1'b0;
    endfunction

    function automatic tlb_entry_t rand_entry();
        tlb_entry_t t;
        t      = '0;
        t.e    = ($urandom_range(0, 3) != 0);
        t.g    = ($urandom_range(0, 3) == 0);
        t.asid = 10'($urandom_range(1, 3));
        t.ps   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
        t.vppn = {8'h5A, 2'($urandom_range(0, 1)), 9'($urandom)};
        t.ppn0 = 20'($urandom); t.plv0 = 2'($urandom); t.mat0 = 2'($urandom);
        t.d0   = 1'($urandom);  t.v0   = 1'($urandom);
        t.ppn1 = 20'($urandom); t.plv1 = 2'($urandom); t.mat1 = 2'($urandom);
        t.d1   = 1'($urandom);  t.v1   = 1'($urandom);
        return t;
    endfunction

    task automatic do_write(input int idx, input tlb_entry_t ent);
        @(negedge clk);
        we = 1'b1; w_index = TLBIDLEN'(idx); w_entry = ent;
        @(negedge clk);
        we = 1'b0;
        m_tlb[idx] = ent;
    endtask

    task automatic do_search(input string tag, input int port, input logic [18:0] vppn,
                             input logic b12, input logic [9:0] asid);
        tlb_result_t got;
        @(negedge clk);
        case (port)
            0: begin s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid; end
            1: begin s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid; end
            default: begin s2_vppn = vppn; s2_va_bit12 = b12; s2_asid = asid; end
        endcase
        #1;
        got = (port == 0) ? s0_result : (port == 1) ? s1_result : s2_result;
        chk($sformatf("%s_p%0d", tag, port), 128'(got), 128'(ref_search(vppn, b12, asid)));
    endtask

    task automatic check_entries(input string tag);
        for (int i = 0; i < TLBNUM; i++) begin
            @(negedge clk);
            r_index = TLBIDLEN'(i);
            #1;
            chk($sformatf("%s_e%0d", tag, i), 128'(r_entry), 128'(m_tlb[i]));
        end
    endtask

    task automatic run_inv(input string tag, input logic [4:0] op, input logic [9:0] asid,
                           input logic [31:0] va);
        int n;
        @(negedge clk);
        invtlb_valid = 1'b1; invtlb_op = op; invtlb_asid = asid; invtlb_va = va;
        @(negedge clk);
        invtlb_valid = 1'b0;
        n = 0;
        while (invtlb_busy && n < 4 * TLBNUM) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 128'(n), (op <= 5'd6) ? 128'(TLBNUM) : 128'(0));
        ref_apply_inv(op, asid, va);
    endtask

    initial begin
        tlb_entry_t  ent;
        tlb_entry_t  ent2;
        tlb_result_t got;
        int          n;
        int          j;
        logic [18:0] qv;

        for (int i = 0; i < TLBNUM; i++) m_tlb[i] = '0;

        // Reset state, both while held and after release.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 128'(invtlb_busy), 128'(0));
        chk("rst_found", 128'(s0_result.found | s1_result.found | s2_result.found), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 3; p++) do_search("post_rst", p, 19'h0, 1'b0, 10'h0);
        @(negedge clk);
        r_index = TLBIDLEN'(5);
        #1;
        chk("post_rst_r5", 128'(r_entry), 128'(0));

        // 4KB entry, odd page.
        ent = '0;
        ent.e = 1'b1; ent.asid = 10'h12; ent.ps = 6'd12; ent.vppn = 19'h1234;
        ent.ppn1 = 20'hABCDE; ent.v1 = 1'b1;
        do_write(3, ent);
        @(negedge clk);
        s0_vppn = 19'h1234; s0_va_bit12 = 1'b1; s0_asid = 10'h12;
        #1;
        got = s0_result;
        chk("4k_found", 128'(got.found), 128'(1));
        chk("4k_index", 128'(got.index), 128'(3));
        chk("4k_ppn", 128'(got.ppn), 128'(20'hABCDE));
        chk("4k_v", 128'(got.v), 128'(1));
        for (int p = 0; p < 3; p++) do_search("4k_hit", p, 19'h1234, 1'b1, 10'h12);
        for (int p = 0; p < 3; p++) do_search("4k_asid_miss", p, 19'h1234, 1'b1, 10'h13);
        @(negedge clk);
        s1_vppn = 19'h1234; s1_va_bit12 = 1'b1; s1_asid = 10'h13;
        #1;
        chk("4k_asid_miss_found", 128'(s1_result.found), 128'(0));

        // 2MB entry: low vppn bits ignored, vppn[8] selects odd page.
        ent = '0;
        ent.e = 1'b1; ent.g = 1'b1; ent.ps = 6'd21; ent.vppn = 19'h1FE00;
        ent.ppn0 = 20'h11111; ent.ppn1 = 20'h22222; ent.v1 = 1'b1;
        do_write(7, ent);
        @(negedge clk);
        s2_vppn = 19'h1FFFF; s2_va_bit12 = 1'b0; s2_asid = 10'h3FF;
        #1;
        chk("2m_found", 128'(s2_result.found), 128'(1));
        chk("2m_index", 128'(s2_result.index), 128'(7));
        chk("2m_ppn_odd", 128'(s2_result.ppn), 128'(20'h22222));
        do_search("2m_hit", 1, 19'h1FE00, 1'b1, 10'h0);

        // INVTLB op 4 on asid 4.
        ent = '0; ent.e = 1'b1; ent.g = 1'b1; ent.vppn = 19'h00100; ent.ps = 6'd12;
        do_write(0, ent);
        ent.g = 1'b0; ent.asid = 10'd4; ent.vppn = 19'h00200;
        do_write(1, ent);
        ent.asid = 10'd5; ent.vppn = 19'h00300;
        do_write(2, ent);
        run_inv("op4", 5'd4, 10'd4, 32'h0);
        check_entries("op4");
        @(negedge clk);
        r_index = TLBIDLEN'(1); #1;
        chk("op4_e1_cleared", 128'(r_entry.e), 128'(0));
        r_index = TLBIDLEN'(2); #1;
        chk("op4_e2_kept", 128'(r_entry.e), 128'(1));

        // Illegal op: no busy, nothing changes.
        run_inv("op7", 5'd7, 10'd5, 32'h0);
        check_entries("op7");

        // Write plus op 0 together; a second request and a write mid-sweep are dropped.
        ent = rand_entry(); ent.e = 1'b1;
        ent2 = rand_entry(); ent2.e = 1'b1;
        @(negedge clk);
        we = 1'b1; w_index = TLBIDLEN'(9); w_entry = ent;
        invtlb_valid = 1'b1; invtlb_op = 5'd0; invtlb_asid = '0; invtlb_va = '0;
        @(negedge clk);
        we = 1'b0; invtlb_valid = 1'b0;
        m_tlb[9] = ent;
        n = 0;
        while (invtlb_busy && n < 4 * TLBNUM) begin
            n++;
            if (n == 8) begin
                invtlb_valid = 1'b1; invtlb_op = 5'd4;
                we = 1'b1; w_index = TLBIDLEN'(2); w_entry = ent2;
            end else begin
                invtlb_valid = 1'b0; we = 1'b0;
            end
            @(negedge clk);
        end
        invtlb_valid = 1'b0; we = 1'b0;
        ref_apply_inv(5'd0, 10'd0, 32'h0);
        chk("wr_inv_busy_cycles", 128'(n), 128'(TLBNUM));
        @(negedge clk);
        chk("wr_inv_busy_idle", 128'(invtlb_busy), 128'(0));
        check_entries("wr_inv");

        // Randomized traffic against the model.
        for (int it = 0; it < 120; it++) begin
            j = $urandom_range(0, 9);
            if (j < 4) begin
                do_write($urandom_range(0, TLBNUM - 1), rand_entry());
            end else if (j < 9) begin
                ent = m_tlb[$urandom_range(0, TLBNUM - 1)];
                qv  = ($urandom_range(0, 3) == 0) ? {8'h5A, 2'($urandom_range(0, 1)), 9'($urandom)}
                                                  : ent.vppn;
                if (ent.ps == 6'd21) qv[8:0] = 9'($urandom);
                do_search("rnd_srch", $urandom_range(0, 2), qv, 1'($urandom),
                          10'($urandom_range(1, 3)));
            end else begin
                ent = m_tlb[$urandom_range(0, TLBNUM - 1)];
                run_inv("rnd_inv", 5'($urandom_range(2, 7)), 10'($urandom_range(1, 3)),
                        {ent.vppn, 13'($urandom)});
                check_entries("rnd_inv");
            end
        end
        for (int op = 6; op >= 2; op--) begin
            for (int k = 0; k < 4; k++) do_write($urandom_range(0, TLBNUM - 1), rand_entry());
            ent = m_tlb[$urandom_range(0, TLBNUM - 1)];
            run_inv($sformatf("op%0d", op), 5'(op), ent.asid, {ent.vppn, 13'($urandom)});
            check_entries($sformatf("op%0d", op));
        end

        // Reset in the middle of a sweep.
        for (int i = 0; i < TLBNUM; i++) begin
            ent = rand_entry(); ent.e = 1'b1;
            do_write(i, ent);
        end
        @(negedge clk);
        invtlb_valid = 1'b1; invtlb_op = 5'd3; invtlb_asid = 10'd1; invtlb_va = '0;
        @(negedge clk);
        invtlb_valid = 1'b0;
        n = 1;
        while (n < 5) begin
            n++;
            @(negedge clk);
        end
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 128'(invtlb_busy), 128'(0));
        for (int i = 0; i < TLBNUM; i++) m_tlb[i] = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            r_index = TLBIDLEN'(i);
            #1;
            chk($sformatf("midrst_e%0d", i), 128'(r_entry), 128'(0));
        end
        s0_vppn = m_tlb[0].vppn;
        #1;
        chk("midrst_found", 128'(s0_result.found | s1_result.found | s2_result.found), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy_after", 128'(invtlb_busy), 128'(0));
        check_entries("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
